// File: rtl/token_decoder.sv
// Token decoder: expands token IDs (vocabulary start addresses) into the zero-terminated byte strings they name.
// Define TOKEN_DECODER_SEP_EN to append a 0x00 separator byte after every token.
module token_decoder #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic [ADDR_WIDTH-1:0] tok_base,
  input  logic [ADDR_WIDTH:0]   tok_count,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  input  logic [DATA_WIDTH-1:0] tok_dout,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_dout,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   out_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_ADDR,
    S_T_DATA,
    S_V_ADDR,
    S_V_DATA,
`ifdef TOKEN_DECODER_SEP_EN
    S_SEP,
`endif
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH:0]   LEN_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] VPTR_MAX = {ADDR_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] tok_ptr_q, tok_ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] vptr_q, vptr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  err_q, err_d;
  logic                  end_tok;

  // Only the low ADDR_WIDTH bits of a token word form a vocabulary address.
  if (DATA_WIDTH > ADDR_WIDTH) begin : g_tok_hi
    logic unused_tok_hi;
    assign unused_tok_hi = ^tok_dout[DATA_WIDTH-1:ADDR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tok_ptr_q <= '0;
      rem_q     <= '0;
      vptr_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tok_ptr_q <= tok_ptr_d;
      rem_q     <= rem_d;
      vptr_q    <= vptr_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tok_ptr_d = tok_ptr_q;
    rem_d     = rem_q;
    vptr_d    = vptr_q;
    len_d     = len_q;
    err_d     = err_q;
    end_tok   = 1'b0;
    out_we    = 1'b0;
    out_addr  = '0;
    out_din   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cs) begin
          tok_ptr_d = tok_base;
          rem_d     = tok_count;
          len_d     = '0;
          err_d     = 1'b0;
          state_d   = (tok_count == '0) ? S_DONE : S_T_ADDR;
        end
      end
      S_T_ADDR: state_d = S_T_DATA;
      S_T_DATA: begin
        vptr_d  = tok_dout[ADDR_WIDTH-1:0];
        state_d = S_V_ADDR;
      end
      S_V_ADDR: state_d = S_V_DATA;
      S_V_DATA: begin
        if (voc_dout == '0) begin
          end_tok = 1'b1;
        end else if (len_q == LEN_FULL) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          out_we   = 1'b1;
          out_addr = len_q[ADDR_WIDTH-1:0];
          out_din  = voc_dout;
          len_d    = len_q + LEN_ONE;
          state_d  = S_V_ADDR;
          // A string running into the top of the vocabulary ends there instead of wrapping.
          if (vptr_q == VPTR_MAX) begin
            end_tok = 1'b1;
          end else begin
            vptr_d = vptr_q + 1'b1;
          end
        end
        if (end_tok) begin
          tok_ptr_d = tok_ptr_q + 1'b1;
          rem_d     = rem_q - LEN_ONE;
`ifdef TOKEN_DECODER_SEP_EN
          state_d   = S_SEP;
`else
          state_d   = (rem_q == LEN_ONE) ? S_DONE : S_T_ADDR;
`endif
        end
      end
`ifdef TOKEN_DECODER_SEP_EN
      S_SEP: begin
        if (len_q == LEN_FULL) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          out_we   = 1'b1;
          out_addr = len_q[ADDR_WIDTH-1:0];
          len_d    = len_q + LEN_ONE;
          state_d  = (rem_q == '0) ? S_DONE : S_T_ADDR;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tok_addr = tok_ptr_q;
  assign voc_addr = vptr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign out_len  = len_q;

endmodule

// File: doc/token_decoder.md
# token_decoder

Inverse of the vocabulary encoder. Reads a list of token IDs (vocabulary start addresses) from a token SRAM. For each token, copies the zero-terminated byte string at that address in the vocabulary SRAM into an output text SRAM. It sits after the encoder output RAM and drives the three single-port, 1-cycle-read-latency `sram` instances through plain address/data ports.

## Interface
- `ADDR_WIDTH`, default 4: address width of all three SRAMs.
- `DATA_WIDTH`, default 8: byte/token width; must be ≥ `ADDR_WIDTH`.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cs` in 1: start request, sampled only in IDLE.
- `tok_base` in `ADDR_WIDTH`: first token address, latched on start.
- `tok_count` in `ADDR_WIDTH+1`: number of tokens, latched on start.
- `tok_addr` out `ADDR_WIDTH`: token SRAM read address.
- `tok_dout` in `DATA_WIDTH`: token SRAM read data, valid 1 cycle after address.
- `voc_addr` out `ADDR_WIDTH`: vocabulary SRAM read address.
- `voc_dout` in `DATA_WIDTH`: vocabulary SRAM read data, 1-cycle latency.
- `out_addr` out `ADDR_WIDTH`: output SRAM write address.
- `out_din` out `DATA_WIDTH`: output SRAM write data.
- `out_we` out 1: output SRAM write enable, 1-cycle pulse per byte.
- `busy` out 1: high from the cycle after start until DONE inclusive.
- `done` out 1: 1-cycle completion pulse.
- `err` out 1: output overflow flag, held until next start.
- `out_len` out `ADDR_WIDTH+1`: bytes written in the last run.

## Operation
- States: IDLE, T_ADDR, T_DATA, V_ADDR, V_DATA, SEP, DONE.
- IDLE → T_ADDR on `cs`:
  - latch `tok_base` into `tok_ptr` and `tok_count` into `remaining`;
  - clear `out_ptr`, `out_len`, `err`.
- If the latched `tok_count`==0, go IDLE → DONE directly with no memory access.
- T_ADDR: `tok_addr`=`tok_ptr`; go to T_DATA.
- T_DATA: `vptr` ← `tok_dout[ADDR_WIDTH-1:0]`; go to V_ADDR.
- V_ADDR: `voc_addr`=`vptr`; go to V_DATA.
- V_DATA, case `voc_dout`==0 (end of token):
  - `tok_ptr`++ and `remaining`--;
  - go to SEP if the separator is enabled, else T_ADDR, or DONE when `remaining` reaches 0.
- V_DATA, case `voc_dout`≠0:
  - assert `out_we`, `out_addr`=`out_ptr`, `out_din`=`voc_dout`;
  - `out_ptr`++, `out_len`++, `vptr`++;
  - go to V_ADDR.
  - If `vptr` was all-ones, the byte is written and the token is then ended as if a terminator were read (no vocab wrap).
- SEP: write `out_din`=0 at `out_ptr` (same pointer and length rules), then go to T_ADDR or DONE.
- Overflow: any write while `out_len`==2^`ADDR_WIDTH` is suppressed (`out_we`=0). Instead set `err`=1 and go to DONE.
- `tok_ptr` wraps modulo 2^`ADDR_WIDTH`; this is allowed.
- DONE: `done`=1 for one cycle, then go to IDLE. `out_len` and `err` hold until the next start.
- `cs` outside IDLE is ignored.
- Reset values: state IDLE; all outputs 0, including `tok_addr`, `voc_addr`, `out_addr`, `out_din`, `out_we`, `busy`, `done`, `err`, `out_len`.
- Reset mid-run: at the next edge go to IDLE with `out_we`=0. Partial output RAM contents are left as-is.

## Timing
- Start accepted at edge N ⇒ T_ADDR in cycle N+1; `busy` rises at N+1.
- Per token of L non-zero bytes: 2 + 2·(L+1) cycles, plus 1 cycle for SEP when enabled.
- DONE occupies exactly one cycle after the last token's end; `busy` falls at the cycle after DONE.
- Address outputs are registered state-derived values. Read data is used exactly one cycle after its address state.
- `out_we`, `out_addr` and `out_din` are combinational from state and `voc_dout` in V_DATA and SEP. They are stable before the next edge.

## Configuration
- `TOKEN_DECODER_SEP_EN` defined: the SEP state exists; a 0x00 byte is written after every token, including the last, and counts in `out_len`.
- Not defined: SEP is compiled out; V_DATA at end-of-token goes straight to T_ADDR or DONE, and the output is concatenated bytes.

## Test plan
- Vocab [0]=0x68, [1]=0x65, [2]=0x00, [3]=0x79, [4]=0x00; tokens [0]=0, [1]=3; `tok_base`=0, `tok_count`=2; no SEP:
  - output 0x68 0x65 0x79;
  - `out_len`=3, `err`=0;
  - `done` exactly 14 cycles after `busy` rises.
- Same stimulus with `TOKEN_DECODER_SEP_EN`:
  - output 0x68 0x65 0x00 0x79 0x00;
  - `out_len`=5;
  - `done` at 16 cycles.
- `tok_count`=0 with `cs`: `done` 1 cycle after start, `out_we` never asserted, `out_len`=0.
- Vocab bytes 1..15 all non-zero, token 1, `tok_count`=2 (16+ bytes needed) ⇒ 15 writes, then the second token fills slot 15; the next write is suppressed, `err`=1, and `done` pulses.
- `rst` asserted in V_DATA mid-token, then `cs` restart with the first test vector ⇒ the same output as the first test and `out_len`=3.
- Vocab entry at address 15=0x41 with no terminator, token 15, count 1 ⇒ one write of 0x41, then the token ends and `done` pulses; `voc_addr` never wraps to 0.
